// File: rtl/secded_pkg.sv
// Shared constants and types for the SECDED(13,8) frame receiver.
// Optional feature macro: SECDED_RX_CONCEAL_EN (see secded_frame_receiver).
package secded_pkg;

    localparam int CW_W       = 13;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 39;
    localparam int SAMPLE_W   = 24;
    localparam int NUM_CW     = 3;

    // Hamming position carrying data bit k
    localparam logic [3:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE
    } state_t;

    typedef enum logic [1:0] {
        CLEAN,
        CORRECTED,
        UNCORRECTABLE
    } dec_status_t;

endpackage

// File: rtl/secded_dec_13_8.sv
// Combinational SECDED(13,8) decoder: corrects one bit, detects two.
// Status encoding comes from secded_pkg::dec_status_t.
module secded_dec_13_8
    import secded_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        status
);

    logic [3:0]      syn;
    logic            par;
    logic [CW_W-1:0] fixed;

    always_comb begin
        syn    = '0;
        par    = ^cw;
        fixed  = cw;
        status = CLEAN;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) syn = syn ^ 4'(i);
        end
        if (par) begin
            if (syn <= 4'd12) begin
                // syn == 0 means the overall parity bit itself flipped
                fixed  = cw ^ (13'd1 << syn);
                status = CORRECTED;
            end else begin
                status = UNCORRECTABLE;
            end
        end else if (syn != 4'd0) begin
            status = UNCORRECTABLE;
        end
        data = '0;
        for (int k = 0; k < DATA_W; k++) begin
            data[k] = fixed[DATA_POS[k]];
        end
    end

endmodule

// File: rtl/secded_frame_receiver.sv
// Deserializes 39-bit frames (3 x SECDED(13,8)) into 24-bit samples.
// Define SECDED_RX_CONCEAL_EN to repeat the last clean sample on errors.
module secded_frame_receiver
    import secded_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_bit,
    input  logic                rx_valid,
    input  logic                rx_sof,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [2:0]          sample_corr,
    output logic [2:0]          sample_uncorr,
    output logic                overrun,
    output logic [CNT_W-1:0]    corr_cnt,
    output logic [CNT_W-1:0]    uncorr_cnt
);

    state_t                state, state_nx;
    logic [5:0]            bit_cnt, bit_cnt_nx;
    logic                  shift_en;
    logic [FRAME_BITS-1:0] shreg;
    logic [SAMPLE_W-1:0]   dec_data;
    logic [SAMPLE_W-1:0]   out_data;
    logic [1:0]            dec_st [NUM_CW];
    logic [2:0]            corr_vec, uncorr_vec;
    logic                  decoding, load;

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid && rx_sof) begin
                    shift_en   = 1'b1;
                    bit_cnt_nx = 6'd1;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (rx_valid) begin
                    shift_en = 1'b1;
                    if (rx_sof) begin
                        bit_cnt_nx = 6'd1;
                    end else begin
                        bit_cnt_nx = bit_cnt + 6'd1;
                        if (bit_cnt_nx == 6'(FRAME_BITS)) state_nx = DECODE;
                    end
                end
            end
            DECODE: begin
                bit_cnt_nx = 6'd0;
                state_nx   = IDLE;
                if (rx_valid && rx_sof) begin
                    shift_en   = 1'b1;
                    bit_cnt_nx = 6'd1;
                    state_nx   = SHIFT;
                end
            end
            default: begin
                bit_cnt_nx = 6'd0;
                state_nx   = IDLE;
            end
        endcase
    end

    // Shifting right leaves the first received bit at shreg[0]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            if (shift_en) shreg <= {rx_bit, shreg[FRAME_BITS-1:1]};
        end
    end

    for (genvar j = 0; j < NUM_CW; j++) begin : g_dec
        secded_dec_13_8 u_dec (
            .cw     (shreg[j*CW_W +: CW_W]),
            .data   (dec_data[j*DATA_W +: DATA_W]),
            .status (dec_st[j])
        );
    end

    always_comb begin
        corr_vec   = '0;
        uncorr_vec = '0;
        for (int j = 0; j < NUM_CW; j++) begin
            corr_vec[j]   = (dec_st[j] == CORRECTED);
            uncorr_vec[j] = (dec_st[j] == UNCORRECTABLE);
        end
    end

`ifdef SECDED_RX_CONCEAL_EN
    logic [SAMPLE_W-1:0] held;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) held <= '0;
        else if (load && uncorr_vec == 3'b000) held <= dec_data;
    end

    assign out_data = (|uncorr_vec) ? held : dec_data;
`else
    assign out_data = dec_data;
`endif

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [2:0]       v
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(v[0]) + (CNT_W+1)'(v[1])
            + (CNT_W+1)'(v[2]);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign decoding = (state == DECODE);
    assign load     = decoding && (!sample_valid || sample_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            sample_corr   <= '0;
            sample_uncorr <= '0;
            overrun       <= 1'b0;
            corr_cnt      <= '0;
            uncorr_cnt    <= '0;
        end else begin
            overrun <= 1'b0;
            if (decoding) begin
                corr_cnt   <= sat_add(corr_cnt, corr_vec);
                uncorr_cnt <= sat_add(uncorr_cnt, uncorr_vec);
            end
            if (load) begin
                sample_valid  <= 1'b1;
                sample_out    <= out_data;
                sample_corr   <= corr_vec;
                sample_uncorr <= uncorr_vec;
            end else begin
                if (decoding) overrun <= 1'b1;
                if (sample_valid && sample_ready) sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_secded_frame_receiver.sv
// Directed bench for secded_frame_receiver (SECDED_RX_CONCEAL_EN aware).
// Counter width is reduced so saturation is reached in a short run.
module tb_secded_frame_receiver;

    localparam int CW = 8;

`ifdef SECDED_RX_CONCEAL_EN
    localparam logic [23:0] EXP_DBL = 24'h0F0F0F;
    localparam logic [23:0] EXP_TRI = 24'h0F0F0F;
`else
    localparam logic [23:0] EXP_DBL = 24'h0A0F0F;
    localparam logic [23:0] EXP_TRI = 24'h000080;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_bit, rx_valid, rx_sof;
    logic [23:0]   sample_out;
    logic          sample_valid, sample_ready;
    logic [2:0]    sample_corr, sample_uncorr;
    logic          overrun;
    logic [CW-1:0] corr_cnt, uncorr_cnt;

    int n_vec = 0;
    int n_bad = 0;

    secded_frame_receiver #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_bit        (rx_bit),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .sample_corr   (sample_corr),
        .sample_uncorr (sample_uncorr),
        .overrun       (overrun),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        int pos [8];
        int pb;
        logic p;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12};
        c = '0;
        for (int k = 0; k < 8; k++) c[pos[k]] = d[k];
        for (int b = 0; b < 4; b++) begin
            pb = 1 << b;
            p = 1'b0;
            for (int i = 1; i < 13; i++)
                if ((i & pb) != 0 && i != pb) p = p ^ c[i];
            c[pb] = p;
        end
        c[0] = ^c[12:1];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [23:0] s, input logic [38:0] flip);
        logic [38:0] f;
        f = {enc(s[23:16]), enc(s[15:8]), enc(s[7:0])} ^ flip;
        for (int i = 0; i < 39; i++) begin
            rx_valid = 1'b1;
            rx_sof   = (i == 0);
            rx_bit   = f[i];
            tick();
        end
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_bit   = 1'b0;
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_sof   = (i == 0);
            rx_bit   = i[0];
            tick();
        end
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_bit   = 1'b0;
    endtask

    // Called in the DECODE cycle; sample must appear one cycle later
    task automatic expect_sample(input string tag, input logic [23:0] s,
                                 input logic [2:0] c, input logic [2:0] u);
        check({tag, "_dec_cycle_valid"}, 32'(sample_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(sample_valid), 32'd1);
        check({tag, "_data"}, 32'(sample_out), 32'(s));
        check({tag, "_corr"}, 32'(sample_corr), 32'(c));
        check({tag, "_uncorr"}, 32'(sample_uncorr), 32'(u));
    endtask

    task automatic take();
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        check("take_clears_valid", 32'(sample_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"}, 32'(sample_out), 32'd0);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_flags"}, 32'({sample_corr, sample_uncorr}), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'd0);
        check({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'd0);
    endtask

    initial begin
        logic [38:0] m;
        reset        = 1'b1;
        rx_bit       = 1'b0;
        rx_valid     = 1'b0;
        rx_sof       = 1'b0;
        sample_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        send_frame(24'h123456, '0);
        expect_sample("clean", 24'h123456, 3'b000, 3'b000);
        take();
        check("clean_corr_cnt", 32'(corr_cnt), 32'd0);

        send_frame(24'hA5C33C, 39'd1 << 18);
        expect_sample("single", 24'hA5C33C, 3'b010, 3'b000);
        check("single_corr_cnt", 32'(corr_cnt), 32'd1);
        take();

        send_frame(24'h654321, 39'd1);
        expect_sample("cw0", 24'h654321, 3'b001, 3'b000);
        check("cw0_corr_cnt", 32'(corr_cnt), 32'd2);
        take();

        send_frame(24'h0F0F0F, '0);
        expect_sample("good", 24'h0F0F0F, 3'b000, 3'b000);
        take();
        send_frame(24'h0F0F0F, (39'd1 << 29) | (39'd1 << 32));
        expect_sample("double", EXP_DBL, 3'b000, 3'b100);
        check("double_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
        take();

        send_frame(24'h000000, (39'd1 << 1) | (39'd1 << 2) | (39'd1 << 12));
        expect_sample("triple", EXP_TRI, 3'b000, 3'b001);
        check("triple_uncorr_cnt", 32'(uncorr_cnt), 32'd2);
        take();

        send_frame(24'h111111, '0);
        send_frame(24'h222222, '0);
        check("ovr_dec_cycle", 32'(overrun), 32'd0);
        check("ovr_hold_data", 32'(sample_out), 32'h111111);
        tick();
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_keep_data", 32'(sample_out), 32'h111111);
        check("ovr_keep_valid", 32'(sample_valid), 32'd1);
        tick();
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        send_frame(24'h333333, '0);
        sample_ready = 1'b1;
        tick();
        check("nogap_valid", 32'(sample_valid), 32'd1);
        check("nogap_data", 32'(sample_out), 32'h333333);
        check("nogap_overrun", 32'(overrun), 32'd0);
        tick();
        sample_ready = 1'b0;
        check("nogap_drain", 32'(sample_valid), 32'd0);

        send_partial(20);
        send_frame(24'h00FF00, '0);
        expect_sample("restart", 24'h00FF00, 3'b000, 3'b000);
        take();
        repeat (5) tick();
        check("restart_single_output", 32'(sample_valid), 32'd0);

        send_frame(24'h0A0B0C, '0);
        tick();
        tick();
        check("pre_reset_valid", 32'(sample_valid), 32'd1);
        send_partial(30);
        reset = 1'b1;
        #2;
        check_reset_outputs("midreset");
        tick();
        reset = 1'b0;
        tick();
        send_frame(24'h13579B, 39'd1 << 35);
        expect_sample("post_reset", 24'h13579B, 3'b100, 3'b000);
        check("post_reset_corr_cnt", 32'(corr_cnt), 32'd1);
        take();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        m = '0;
        m[7]  = 1'b1;
        m[15] = 1'b1;
        m[37] = 1'b1;
        sample_ready = 1'b1;
        for (int i = 0; i < 84; i++) send_frame(24'h5A5A5A ^ 24'(i), m);
        tick();
        tick();
        check("sat_pre", 32'(corr_cnt), 32'd252);
        for (int i = 0; i < 2; i++) send_frame(24'hC3C3C3, m);
        tick();
        tick();
        check("sat_full", 32'(corr_cnt), 32'd255);
        check("sat_uncorr_zero", 32'(uncorr_cnt), 32'd0);
        sample_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/secded_frame_receiver.md
# secded_frame_receiver

- Receive end of the noisy-channel audio link.
- Takes the serial bitstream leaving the channel medium and deserializes one 39-bit frame: three SECDED(13,8) codewords carrying one 24-bit sample.
- Corrects single-bit errors and flags uncorrectable codewords.
- Presents the sample on a valid/ready interface to the audio sink.
- Sits between the medium and the playback path.

## Interface
Parameters:
- CNT_W, 16, width of the saturating error counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_bit  in  1  serial data bit from the medium
- rx_valid  in  1  rx_bit is valid this cycle
- rx_sof  in  1  qualifies rx_bit as the first bit of a frame (ignored unless rx_valid=1)
- sample_out  out  24  decoded sample
- sample_valid  out  1  sample_out valid
- sample_ready  in  1  sink accepts the sample
- sample_corr  out  3  per byte: a single-bit error was corrected
- sample_uncorr  out  3  per byte: uncorrectable error
- overrun  out  1  one-cycle pulse when a completed frame is dropped
- corr_cnt  out  CNT_W  codewords corrected
- uncorr_cnt  out  CNT_W  codewords uncorrectable

## Operation
**Codeword format**
- cw[12:0]; cw[i] is Hamming position i.
- Parity bits at positions 1, 2, 4 and 8.
- Data d0..d7 at positions 3, 5, 6, 7, 9, 10, 11 and 12.
- cw[0] is even parity over cw[12:1].
- Transmission order: cw[0] first.
- Frame order: byte for sample[7:0], then [15:8], then [23:16]; 39 bits total.

**FSM**
- IDLE: wait for rx_valid & rx_sof, which captures bit 1 and moves to SHIFT. rx_valid bits without rx_sof are ignored.
- SHIFT: capture each rx_valid bit. A 6-bit counter counts to 39, then moves to DECODE.
- DECODE: one cycle. Decodes all three codewords in parallel, then returns to IDLE.
- rx_sof at any point in SHIFT discards the partial frame and restarts at bit 1 with that bit.

**Decode, per codeword**
- s = 4-bit XOR of indices of set bits in positions 1..12.
- q = XOR of all 13 bits.
- q=0, s=0: clean.
- q=1, s≤12: single error at position s (s=0 means cw[0]). Flip the bit and set the corr bit.
- q=0, s≠0: uncorrectable (double error). Set the uncorr bit; data is passed uncorrected.
- q=1, s>12: uncorrectable. Set the uncorr bit; data is passed uncorrected.

**Output register**
- Loaded at the end of DECODE if sample_valid=0, or if sample_valid=1 and sample_ready=1 in that same cycle.
- Otherwise the new frame is dropped and overrun pulses. Counters still update for a dropped frame.
- sample_valid clears on sample_valid & sample_ready unless a new load happens in that same cycle.
- sample_out and the flags are stable while sample_valid=1 and sample_ready=0.

**Counters**
- Increment per codeword, by up to 3 in one cycle.
- Saturate at all-ones.
- Cleared only by reset.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE, bit counter 0
  - concealment history 0
- Latency: the 39th bit is presented in cycle N. DECODE occupies cycle N+1. sample_valid is high from cycle N+2.
- A new frame's rx_sof is accepted in cycle N+1. Minimum frame spacing is 40 cycles.
- Reset mid-frame or with sample_valid=1 discards everything immediately.
- No combinational path from sample_ready to any output.

## Configuration
- SECDED_RX_CONCEAL_EN defined:
  - When any byte is uncorrectable, sample_out is the last sample loaded with no uncorr bits set. At reset that held value is 0.
  - sample_uncorr is still reported and uncorr_cnt still counts.
- Not defined: sample_out carries the raw decoded data.

## Structure
- Package secded_pkg holds:
  - CW_W=13, DATA_W=8, FRAME_BITS=39, SAMPLE_W=24
  - the position-to-data-bit mapping constants
  - a state enum {IDLE, SHIFT, DECODE}
  - a decode status enum {CLEAN, CORRECTED, UNCORRECTABLE}
- Sub-module secded_dec_13_8: combinational decoder, instantiated three times. Output is 8-bit data plus status.

## Test plan
- Clean frame encoding 0x123456 → sample_out=0x123456, corr=000, uncorr=000, valid at N+2.
- Flip cw[5] of byte 1 for sample 0xA5C33C → sample_out=0xA5C33C, sample_corr=010, corr_cnt=1.
- Flip cw[3] and cw[6] of byte 2 after a good sample 0x0F0F0F → sample_uncorr=100, uncorr_cnt=1.
  - With SECDED_RX_CONCEAL_EN: sample_out=0x0F0F0F.
- Hold sample_ready=0 across two back-to-back frames → first sample retained, overrun pulses once at the second DECODE.
  - Then raise sample_ready and drive sample_ready=1 in the next DECODE cycle → new sample loaded with no gap.
- rx_sof after 20 bits, then a full frame of 0x00FF00 → single output 0x00FF00.
- Assert reset at bit 30 → all outputs 0. The next full frame decodes correctly.
- 70000 single-error frames → corr_cnt saturates at 0xFFFF.
